mprj_wb_mailbox: RTL and testbench

- User-project-side Wishbone responder for the management SoC's exported mprj_* master bus.
- Holds two FIFOs: TX carries words from the management CPU to user logic; RX carries words from user logic to the CPU.
- Raises an interrupt to the management core on its user irq inputs.
- Sits in the user project area, clocked by the Wishbone clock.

---
 rtl/mprj_wb_mailbox.sv | 138 +++++++++++++
 tb/tb_mprj_wb_mailbox.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_wb_mailbox.sv
// Wishbone mailbox for the user project area: a CPU->user TX FIFO, a
// user->CPU RX FIFO, sticky error flags and a registered interrupt.
module mprj_wb_mailbox #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned DEPTH    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_tx_mem [DEPTH];
  logic [31:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic          r_tx_ovf, r_rx_unf;
  logic [2:0]    r_irq_en;
  logic          r_ack, r_irq;
  logic [31:0]   r_dat;

  logic          w_acc, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic          w_tx_wr, w_tx_push, w_tx_pop, w_rx_rd, w_rx_push, w_rx_pop;
  logic          w_sts_clr, w_en_wr;
  logic [31:0]   w_tx_wdata, w_status, w_rdata;

  // Bus decode; full/empty come from the counts before the edge so a
  // same-edge pop never frees a slot for a push.
  assign w_acc      = wbs_cyc_i & wbs_stb_i & ~r_ack &
                      (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_tx_full  = (r_tx_cnt == CW'(DEPTH));
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CW'(DEPTH));
  assign w_rx_empty = (r_rx_cnt == '0);

  assign w_tx_wr   = w_acc & wbs_we_i & (wbs_adr_i[3:0] == 4'h0) & (|wbs_sel_i);
  assign w_tx_push = w_tx_wr & ~w_tx_full;
  assign w_tx_pop  = ~w_tx_empty & tx_ready;
  assign w_rx_rd   = w_acc & ~wbs_we_i & (wbs_adr_i[3:0] == 4'h4);
  assign w_rx_pop  = w_rx_rd & ~w_rx_empty;
  assign w_rx_push = rx_valid & rx_ready;
  assign w_sts_clr = w_acc & wbs_we_i & (wbs_adr_i[3:0] == 4'h8) & wbs_sel_i[0];
  assign w_en_wr   = w_acc & wbs_we_i & (wbs_adr_i[3:0] == 4'hC) & wbs_sel_i[0];

  assign w_tx_wdata = wbs_dat_i & {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign w_status = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), 2'b00, r_rx_unf, r_tx_ovf,
                     w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

  // Read data mux for the accepted read access.
  always_comb begin
    w_rdata = '0;
    case (wbs_adr_i[3:0])
      4'h4:    w_rdata = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
      4'h8:    w_rdata = w_status;
      4'hC:    w_rdata = {29'b0, r_irq_en};
      default: w_rdata = '0;
    endcase
  end

  // FIFO storage; contents need no reset since counts gate visibility.
  always_ff @(posedge wb_clk_i) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= w_tx_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
  end

  // Control state: bus handshake, pointers, counts, flags and interrupt.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ack <= w_acc;
      if (w_acc & ~wbs_we_i) r_dat <= w_rdata;

      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase

      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase

      if (w_tx_wr & w_tx_full)           r_tx_ovf <= 1'b1;
      else if (w_sts_clr & wbs_dat_i[4]) r_tx_ovf <= 1'b0;
      if (w_rx_rd & w_rx_empty)          r_rx_unf <= 1'b1;
      else if (w_sts_clr & wbs_dat_i[5]) r_rx_unf <= 1'b0;

      if (w_en_wr) r_irq_en <= wbs_dat_i[2:0];

      r_irq <= (r_irq_en[0] & ~w_rx_empty) | (r_irq_en[1] & w_tx_empty) |
               (r_irq_en[2] & (r_tx_ovf | r_rx_unf));
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;
  assign tx_valid  = ~w_tx_empty;
  assign tx_data   = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];
  assign rx_ready  = ~w_rx_full & ~wb_rst_i;

endmodule

// File: tb/tb_mprj_wb_mailbox.sv
// Bench for mprj_wb_mailbox: directed scenarios plus random traffic, all
// checked against a queue-based model of the mailbox.
module tb_mprj_wb_mailbox;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, tx_ready, rx_valid;
  logic [3:0]  sel;
  logic [31:0] adr, dat, rx_data;
  logic        ack, tx_valid, rx_ready, irq;
  logic [31:0] dat_o, tx_data;

  mprj_wb_mailbox #(.BASE_ADR(BASE), .DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] tq[$];
  logic [31:0] rq[$];
  logic        m_ovf, m_unf, m_ack, m_irq;
  logic [2:0]  m_en;
  logic [31:0] m_dat;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tq.delete(); rq.delete();
    m_ovf = 0; m_unf = 0; m_ack = 0; m_irq = 0; m_en = '0; m_dat = '0;
  endtask

  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One clock: predict from the register-map rules, clock, compare.
  task automatic step();
    int tc, rc;
    logic acc, nirq, tpop;
    logic [31:0] st;
    tc = tq.size(); rc = rq.size();
    nirq = (m_en[0] && rc != 0) || (m_en[1] && tc == 0) || (m_en[2] && (m_ovf || m_unf));
    st = 32'(rc != 0) | (32'(rc == DEPTH) << 1) | (32'(tc == 0) << 2) |
         (32'(tc == DEPTH) << 3) | (32'(m_ovf) << 4) | (32'(m_unf) << 5) |
         (32'(rc) << 8) | (32'(tc) << 16);
    acc = cyc && stb && (adr[31:4] == BASE[31:4]) && !m_ack;
    tpop = (tc != 0) && tx_ready;
    if (tpop) void'(tq.pop_front());
    if (acc) begin
      if (we) begin
        case (adr[3:0])
          4'h0: if (sel != 0) begin
                  if (tc == DEPTH) m_ovf = 1;
                  else tq.push_back(lane_mask(dat, sel));
                end
          4'h8: if (sel[0]) begin
                  if (dat[4]) m_ovf = 0;
                  if (dat[5]) m_unf = 0;
                end
          4'hC: if (sel[0]) m_en = dat[2:0];
          default: ;
        endcase
      end else begin
        case (adr[3:0])
          4'h4: if (rc == 0) begin m_dat = 0; m_unf = 1; end
                else m_dat = rq.pop_front();
          4'h8: m_dat = st;
          4'hC: m_dat = {29'b0, m_en};
          default: m_dat = 0;
        endcase
      end
    end
    if (rx_valid && rc < DEPTH) rq.push_back(rx_data);
    m_ack = acc;
    m_irq = nirq;
    @(posedge clk); #1;
    check_val("ack", 32'(ack), 32'(m_ack));
    check_val("dat_o", dat_o, m_dat);
    check_val("tx_valid", 32'(tx_valid), 32'(tq.size() != 0));
    if (tq.size() != 0) check_val("tx_data", tx_data, tq[0]);
    check_val("rx_ready", 32'(rx_ready), 32'(rq.size() < DEPTH));
    check_val("irq", 32'(irq), 32'(m_irq));
  endtask

  // Single bus access plus one idle cycle; returns the registered read data.
  task automatic bus(input logic w, input logic [3:0] off, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    cyc = 1; stb = 1; we = w; adr = BASE + 32'(off); dat = d; sel = s;
    step();
    rd = dat_o;
    cyc = 0; stb = 0; we = 0;
    step();
  endtask

  task automatic do_reset();
    rst = 1; #1;
    check_val("rst_ack", 32'(ack), 0);
    check_val("rst_dat", dat_o, 0);
    check_val("rst_irq", 32'(irq), 0);
    check_val("rst_txv", 32'(tx_valid), 0);
    check_val("rst_txd", tx_data, 0);
    check_val("rst_rxr", 32'(rx_ready), 0);
    model_reset();
    cyc = 0; stb = 0; we = 0; rx_valid = 0; tx_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; #1;
    check_val("rel_rxr", 32'(rx_ready), 1);
  endtask

  logic [31:0] rd;
  logic [31:0] offs [5];

  initial begin
    rst = 1; cyc = 0; stb = 0; we = 0; sel = '0; adr = '0; dat = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    model_reset();
    #2;
    do_reset();
    step();

    // TX words appear in order; TX empty afterwards
    begin
      logic [31:0] words [3];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
        tx_ready = 0;
        bus(1, 4'h0, words[i], 4'hF, rd);
        check_val("tx_seq", tx_data, words[i]);
        tx_ready = 1;
        step();
      end
    end
    tx_ready = 0;
    bus(0, 4'h8, 0, 4'hF, rd);
    check_val("sts_txempty", rd, 32'h0000_0004);

    // TX overflow and write-1-to-clear
    for (int i = 0; i < 9; i++) bus(1, 4'h0, 32'h100 + 32'(i), 4'hF, rd);
    bus(0, 4'h8, 0, 4'hF, rd);
    check_val("sts_ovf", rd, 32'h0008_0018);
    bus(1, 4'h8, 32'h10, 4'hF, rd);
    bus(0, 4'h8, 0, 4'hF, rd);
    check_val("sts_ovf_clr", rd, 32'h0008_0008);
    tx_ready = 1;
    repeat (9) step();
    tx_ready = 0;

    // RX path, interrupt and underflow
    bus(1, 4'hC, 32'h1, 4'h1, rd);
    rx_valid = 1; rx_data = 32'hA5A5_0001; step();
    rx_valid = 0;
    check_val("irq_lat0", 32'(irq), 0);
    step();
    check_val("irq_lat1", 32'(irq), 1);
    rx_valid = 1; rx_data = 32'hA5A5_0002; step();
    rx_valid = 0;
    bus(0, 4'h4, 0, 4'hF, rd);
    check_val("rx_rd1", rd, 32'hA5A5_0001);
    bus(0, 4'h4, 0, 4'hF, rd);
    check_val("rx_rd2", rd, 32'hA5A5_0002);
    check_val("irq_off", 32'(irq), 0);
    bus(0, 4'h4, 0, 4'hF, rd);
    check_val("rx_rd_empty", rd, 0);
    bus(0, 4'h8, 0, 4'hF, rd);
    check_val("sts_unf", rd, 32'h0000_0024);
    bus(1, 4'h8, 32'h20, 4'h1, rd);
    bus(1, 4'hC, 32'h0, 4'h1, rd);

    // RX full with simultaneous user offer and CPU pop
    rx_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin rx_data = 32'h200 + 32'(i); step(); end
    check_val("rx_full_rdy", 32'(rx_ready), 0);
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4; sel = 4'hF; #1;
    check_val("rx_full_pre", 32'(rx_ready), 0);
    step();
    check_val("rx_full_pop", dat_o, 32'h200);
    check_val("rx_full_post", 32'(rx_ready), 1);
    rx_valid = 0; cyc = 0; stb = 0;
    step();
    bus(0, 4'h8, 0, 4'hF, rd);
    check_val("sts_rx7", rd, 32'h0000_0705);
    for (int i = 1; i < DEPTH; i++) begin
      bus(0, 4'h4, 0, 4'hF, rd);
      check_val("rx_drain", rd, 32'h200 + 32'(i));
    end

    // Byte-lane masking and address miss
    bus(1, 4'h0, 32'hDEAD_BEEF, 4'b0101, rd);
    check_val("lane_mask", tx_data, 32'h00AD_00EF);
    tx_ready = 1; step(); tx_ready = 0;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("no_ack_miss", 32'(ack), 0);
    end
    cyc = 0; stb = 0; step();

    // Reset in the middle of an access with data in both FIFOs
    for (int i = 0; i < 3; i++) bus(1, 4'h0, 32'h300 + 32'(i), 4'hF, rd);
    rx_valid = 1;
    for (int i = 0; i < 3; i++) begin rx_data = 32'h400 + 32'(i); step(); end
    rx_valid = 0;
    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h4;
    step();
    do_reset();
    step();
    bus(0, 4'h8, 0, 4'hF, rd);
    check_val("sts_after_rst", rd, 32'h0000_0004);

    // Random traffic against the model
    offs[0] = 32'h0; offs[1] = 32'h4; offs[2] = 32'h8; offs[3] = 32'hC; offs[4] = 32'h10;
    for (int n = 0; n < 3000; n++) begin
      cyc      = ($urandom_range(0, 9) < 6);
      stb      = cyc ? ($urandom_range(0, 9) < 9) : 1'b0;
      we       = $urandom_range(0, 1);
      adr      = BASE + offs[$urandom_range(0, 4)];
      dat      = $urandom;
      sel      = 4'($urandom);
      tx_ready = ($urandom_range(0, 9) < 4);
      rx_valid = ($urandom_range(0, 9) < 5);
      rx_data  = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
